// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter:
//   state_t            FSM state encoding (3 bits)
//   DEF_*              default parameter values for the arbiter
//   idx_width()        width of a requester index (at least 1 bit)
//   wrap_inc()         round-robin pointer step with explicit wrap-around
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_START_TIMEOUT = 7;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wrap is done by comparison so non-power-of-2 requester counts never
  // land on an index that does not exist.
  function automatic int wrap_inc(input int idx, input int n);
    if (idx >= n - 1) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin priority search. The first asserted
// request at or above ptr (wrapping past the top) wins.
// Ports:
//   req      in   NUM_REQ   request vector
//   ptr      in   GW        index that has highest priority this time
//   grant    out  NUM_REQ   one-hot winner (zero when nothing requests)
//   idx      out  GW        binary index of the winner
//   any_req  out  1         at least one request is asserted
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int GW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      idx,
  output logic               any_req
);

  // Walk the requesters starting at ptr; the found flag freezes the
  // first hit so later candidates cannot overwrite it.
  always_comb begin : search
    int   pos;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos[GW-1:0]]) begin
        found            = 1'b1;
        grant[pos[GW-1:0]] = 1'b1;
        idx              = pos[GW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART byte transmitter among NUM_REQ requesters with
// round-robin arbitration. A requester keeps the line for a multi-byte
// packet until it presents a byte with req_last set. Each byte is issued
// with a one-cycle tx_start and the transmitter's busy is followed through
// a full low->high->low frame before the next byte goes out.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   req_valid     per-requester byte valid
//   req_data      per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   req_last      byte closes its packet and releases the lock
//   req_ready     byte accepted this cycle (one-hot or zero)
//   tx_start      one-cycle start pulse to the transmitter
//   tx_data       byte to the transmitter, valid while tx_start=1
//   tx_busy       transmitter busy
//   grant_id      current or most recent granted requester
//   active        a packet is in progress
//   err_timeout   one-cycle pulse when busy never rose after a start
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ       = DEF_NUM_REQ,
  parameter  int DATA_W        = DEF_DATA_W,
  parameter  int START_TIMEOUT = DEF_START_TIMEOUT,
  localparam int GW            = idx_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [GW-1:0]             grant_id,
  output logic                      active,
  output logic                      err_timeout
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  state_t              state;
  logic [GW-1:0]       rr_ptr;
  logic                last_q;
  logic [TW-1:0]       timeout_cnt;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [GW-1:0]       arb_idx;
  logic                arb_any;
  logic [GW-1:0]       next_ptr;
  logic [NUM_REQ-1:0]  held_onehot;
  logic [DATA_W-1:0]   lane [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  assign next_ptr    = GW'(wrap_inc(int'(grant_id), NUM_REQ));
  assign held_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

  // Main FSM. Outputs are registered here and set on the edge that enters
  // START, so tx_start, tx_data and req_ready are all high together for
  // exactly the START cycle. The timeout counter starts at 1 because the
  // START cycle already counts as one elapsed cycle; err_timeout therefore
  // lands START_TIMEOUT cycles after the start pulse. A busy seen in the
  // final WAIT_HI cycle wins over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      last_q      <= 1'b0;
      timeout_cnt <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any && !tx_busy) begin
            grant_id  <= arb_idx;
            req_ready <= arb_grant;
            tx_start  <= 1'b1;
            tx_data   <= lane[arb_idx];
            active    <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          last_q      <= req_last[grant_id];
          timeout_cnt <= TW'(1);
          state       <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (timeout_cnt == TW'(START_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            rr_ptr      <= next_ptr;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q) begin
              rr_ptr <= next_ptr;
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (req_valid[grant_id]) begin
            req_ready <= held_onehot;
            tx_start  <= 1'b1;
            tx_data   <= lane[grant_id];
            state     <= START;
          end
        end
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with a small transmitter model that
// raises busy the cycle after a start and holds it for FRAME cycles.
module tb_uart_tx_arbiter;

  localparam int FRAME = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  logic [7:0]  lane [4];
  logic        model_busy;
  logic        force_busy;
  logic        stuck;
  int          bcnt;
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;

  assign req_data = {lane[3], lane[2], lane[1], lane[0]};
  assign tx_busy  = model_busy | force_busy;

  uart_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model; shares the arbiter's reset. With stuck set it
  // ignores starts so busy never rises.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end else if (tx_start && !stuck) begin
      model_busy <= 1'b1;
      bcnt       <= FRAME;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else if (bcnt == 1) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end
  end

  // Continuous checks: req_ready one-hot or zero, and no second start
  // before the previous frame's busy has fallen (or a timeout ended it).
  bit   pending = 1'b0;
  logic chk_prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pending       = 1'b0;
      chk_prev_busy = 1'b0;
    end else begin
      if (req_ready != 4'b0 || tx_start) begin
        tests++;
        if (!$onehot0(req_ready)) begin
          failed++;
          $display("[TB] FAIL ready_onehot: got %b, expected one-hot or zero", req_ready);
        end
      end
      if (chk_prev_busy && !tx_busy) pending = 1'b0;
      if (err_timeout) pending = 1'b0;
      if (tx_start) begin
        tests++;
        if (pending) begin
          failed++;
          $display("[TB] FAIL start_per_frame: got second start at cycle %0d, expected none before busy falls", cyc);
        end
        pending = 1'b1;
      end
      chk_prev_busy = tx_busy;
    end
  end

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    force_busy = 1'b0;
    stuck      = 1'b0;
    for (int i = 0; i < 4; i++) lane[2'(i)] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!active && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0) begin failed++; $display("[TB] FAIL rst_ready: got %b, expected 0000", req_ready); end
    tests++; if (tx_start !== 1'b0) begin failed++; $display("[TB] FAIL rst_start: got %b, expected 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin failed++; $display("[TB] FAIL rst_data: got %h, expected 00", tx_data); end
    tests++; if (grant_id !== 2'd0) begin failed++; $display("[TB] FAIL rst_grant: got %0d, expected 0", grant_id); end
    tests++; if (active !== 1'b0) begin failed++; $display("[TB] FAIL rst_active: got %b, expected 0", active); end
    tests++; if (err_timeout !== 1'b0) begin failed++; $display("[TB] FAIL rst_err: got %b, expected 0", err_timeout); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_byte();
    int         starts = 0;
    int         start_iter = -1;
    logic [7:0] got_data = '0;
    logic [3:0] got_ready = '0;
    @(posedge clk); #1;
    lane[2] = 8'h55; req_last[2] = 1'b1; req_valid[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start) begin
        starts++;
        if (start_iter < 0) begin
          start_iter = i; got_data = tx_data; got_ready = req_ready;
        end
      end
      @(posedge clk); #1;
      if (starts > 0) req_valid[2] = 1'b0;
    end
    @(negedge clk);
    tests++; if (starts != 1) begin failed++; $display("[TB] FAIL single_starts: got %0d, expected 1", starts); end
    tests++; if (start_iter != 1) begin failed++; $display("[TB] FAIL single_latency: got %0d, expected 1", start_iter); end
    tests++; if (got_data !== 8'h55) begin failed++; $display("[TB] FAIL single_data: got %h, expected 55", got_data); end
    tests++; if (got_ready !== 4'b0100) begin failed++; $display("[TB] FAIL single_ready: got %b, expected 0100", got_ready); end
    tests++; if (active !== 1'b0) begin failed++; $display("[TB] FAIL single_active: got %b, expected 0", active); end
    tests++; if (grant_id !== 2'd2) begin failed++; $display("[TB] FAIL single_grant: got %0d, expected 2", grant_id); end
  endtask

  task automatic test_round_robin();
    int         exp_order [5] = '{0, 1, 2, 3, 0};
    int         served [4] = '{0, 0, 0, 0};
    int         k = 0;
    int         g;
    logic [3:0] took;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) lane[2'(i)] = 8'(i << 4);
    req_last = 4'b1111; req_valid = 4'b1111;
    for (int c = 0; c < 200 && k < 5; c++) begin
      @(negedge clk);
      took = req_ready;
      if (tx_start) begin
        g     = exp_order[k];
        exp_d = 8'((g << 4) | served[g]);
        tests++; if (grant_id !== 2'(g)) begin failed++; $display("[TB] FAIL rr_grant%0d: got %0d, expected %0d", k, grant_id, g); end
        tests++; if (tx_data !== exp_d) begin failed++; $display("[TB] FAIL rr_data%0d: got %h, expected %h", k, tx_data, exp_d); end
        k++;
      end
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++)
        if (took[2'(j)]) begin
          served[j]++;
          lane[2'(j)] = 8'((j << 4) | served[j]);
        end
    end
    req_valid = '0;
    tests++; if (k != 5) begin failed++; $display("[TB] FAIL rr_budget: got %0d starts, expected 5", k); end
  endtask

  task automatic test_packet_lock();
    int         exp_g [4] = '{1, 1, 1, 0};
    logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'hC0};
    int         k = 0;
    int         sent1 = 0;
    int         fall_cyc = -100;
    logic       prev_b = 1'b0;
    logic [3:0] took;
    bit         ok;
    do_reset();
    lane[1] = 8'h10; req_last[1] = 1'b0; req_valid[1] = 1'b1;
    for (int c = 0; c < 300 && k < 4; c++) begin
      @(negedge clk);
      if (prev_b && !tx_busy) fall_cyc = cyc;
      prev_b = tx_busy;
      took = req_ready;
      if (tx_start) begin
        tests++; if (grant_id !== 2'(exp_g[k])) begin failed++; $display("[TB] FAIL lock_grant%0d: got %0d, expected %0d", k, grant_id, exp_g[k]); end
        tests++; if (tx_data !== exp_d[k]) begin failed++; $display("[TB] FAIL lock_data%0d: got %h, expected %h", k, tx_data, exp_d[k]); end
        if (k == 1 || k == 2) begin
          tests++; if (cyc - fall_cyc != 2) begin failed++; $display("[TB] FAIL lock_gap%0d: got %0d, expected 2", k, cyc - fall_cyc); end
        end
        k++;
      end
      @(posedge clk); #1;
      if (took[1]) begin
        sent1++;
        if (sent1 == 1) begin
          lane[1] = 8'h11;
          lane[0] = 8'hC0; req_last[0] = 1'b1; req_valid[0] = 1'b1;
        end else if (sent1 == 2) begin
          lane[1] = 8'h12; req_last[1] = 1'b1;
        end else begin
          req_valid[1] = 1'b0;
        end
      end
      if (took[0]) req_valid[0] = 1'b0;
    end
    tests++; if (k != 4) begin failed++; $display("[TB] FAIL lock_budget: got %0d starts, expected 4", k); end
    wait_idle(40, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL lock_idle: got busy/active, expected idle"); end
  endtask

  task automatic test_timeout();
    int   start_cyc = -1;
    int   err_cyc = -1;
    int   err_cnt = 0;
    logic err_active = 1'b1;
    logic [1:0] got_grant = 2'd0;
    logic took;
    bit   seen = 1'b0;
    bit   ok;
    do_reset();
    // Serve req2 first so the pointer sits at 3 before the timeout.
    lane[2] = 8'h22; req_last[2] = 1'b1; req_valid[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      took = req_ready[2];
      @(posedge clk); #1;
      if (took) req_valid[2] = 1'b0;
    end
    wait_idle(40, ok);
    @(posedge clk); #1;
    stuck = 1'b1;
    lane[3] = 8'h33; req_last[3] = 1'b1; req_valid[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start && start_cyc < 0) begin start_cyc = cyc; got_grant = grant_id; end
      if (err_timeout) begin
        err_cnt++;
        if (err_cyc < 0) begin err_cyc = cyc; err_active = active; end
      end
      took = req_ready[3];
      @(posedge clk); #1;
      if (took) req_valid[3] = 1'b0;
    end
    tests++; if (got_grant !== 2'd3) begin failed++; $display("[TB] FAIL to_grant: got %0d, expected 3", got_grant); end
    tests++; if (err_cnt != 1) begin failed++; $display("[TB] FAIL to_pulses: got %0d, expected 1", err_cnt); end
    tests++; if (err_cyc - start_cyc != 7) begin failed++; $display("[TB] FAIL to_delay: got %0d, expected 7", err_cyc - start_cyc); end
    tests++; if (err_active !== 1'b0) begin failed++; $display("[TB] FAIL to_active: got %b, expected 0", err_active); end
    stuck = 1'b0;
    lane[0] = 8'hA0; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    lane[3] = 8'hA3; req_last[3] = 1'b1; req_valid[3] = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1'b1;
        tests++; if (grant_id !== 2'd0) begin failed++; $display("[TB] FAIL to_next_grant: got %0d, expected 0", grant_id); end
        tests++; if (tx_data !== 8'hA0) begin failed++; $display("[TB] FAIL to_next_data: got %h, expected a0", tx_data); end
      end
      @(posedge clk); #1;
      if (seen) req_valid = '0;
    end
    tests++; if (!seen) begin failed++; $display("[TB] FAIL to_next_budget: got no start, expected one"); end
    wait_idle(40, ok);
  endtask

  task automatic test_reset_mid_packet();
    bit   seen = 1'b0;
    bit   hit = 1'b0;
    int   busy_cycles = 0;
    logic took;
    bit   ok;
    do_reset();
    lane[2] = 8'h5A; req_last[2] = 1'b0; req_valid[2] = 1'b1;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (seen && tx_busy) busy_cycles++;
      if (tx_start) seen = 1'b1;
      if (busy_cycles == 2) begin
        hit = 1'b1;
      end else begin
        took = req_ready[2];
        @(posedge clk); #1;
        if (took) begin lane[2] = 8'h5B; req_last[2] = 1'b1; end
      end
    end
    tests++; if (!hit) begin failed++; $display("[TB] FAIL mid_reach: got no WAIT_LO, expected busy frame"); end
    tests++; if (active !== 1'b1) begin failed++; $display("[TB] FAIL mid_pre_active: got %b, expected 1", active); end
    reset = 1'b1;
    #1;
    tests++; if (active !== 1'b0) begin failed++; $display("[TB] FAIL mid_active: got %b, expected 0", active); end
    tests++; if (grant_id !== 2'd0) begin failed++; $display("[TB] FAIL mid_grant: got %0d, expected 0", grant_id); end
    tests++; if ({tx_start, req_ready, tx_data, err_timeout} !== 14'b0) begin failed++; $display("[TB] FAIL mid_outputs: got %b/%b/%h/%b, expected all zero", tx_start, req_ready, tx_data, err_timeout); end
    repeat (2) @(posedge clk);
    lane[0] = 8'h0F; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1'b1;
        tests++; if (grant_id !== 2'd0) begin failed++; $display("[TB] FAIL mid_first_grant: got %0d, expected 0", grant_id); end
        tests++; if (tx_data !== 8'h0F) begin failed++; $display("[TB] FAIL mid_first_data: got %h, expected 0f", tx_data); end
      end
      @(posedge clk); #1;
      if (seen) req_valid = '0;
    end
    tests++; if (!seen) begin failed++; $display("[TB] FAIL mid_budget: got no start, expected one"); end
    wait_idle(40, ok);
  endtask

  task automatic test_busy_in_idle();
    int starts = 0;
    int start_i = -1;
    bit ok;
    do_reset();
    force_busy = 1'b1;
    lane[0] = 8'h77; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    tests++; if (starts != 0) begin failed++; $display("[TB] FAIL busy_hold: got %0d starts, expected 0", starts); end
    @(posedge clk); #1;
    force_busy = 1'b0;
    for (int i = 0; i < 6 && start_i < 0; i++) begin
      @(negedge clk);
      if (tx_start) begin
        start_i = i;
        tests++; if (tx_data !== 8'h77) begin failed++; $display("[TB] FAIL busy_data: got %h, expected 77", tx_data); end
      end
      @(posedge clk); #1;
      if (start_i >= 0) req_valid[0] = 1'b0;
    end
    tests++; if (start_i < 1 || start_i > 2) begin failed++; $display("[TB] FAIL busy_release: got start at %0d, expected 1..2", start_i); end
    wait_idle(40, ok);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    force_busy = 1'b0;
    stuck      = 1'b0;
    for (int i = 0; i < 4; i++) lane[2'(i)] = '0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_reset_mid_packet();
    test_busy_in_idle();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
